// File: rtl/cofi_multi.sv
// cofi_multi: horizontal colour blender for RGB video, fixed two-stage latency.
// Stage 1 holds the centre pixel C, stage 2 holds the previous pixel P, and the
// live input acts as the next pixel N. Blanked neighbours are replaced by C so
// blends never reach across a blanking edge.
module cofi_multi #(
  parameter int DW     = 8,
  parameter int MODE_W = 2
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              pix_ce,
  input  logic [MODE_W-1:0] mode,
  input  logic              hblank,
  input  logic              vblank,
  input  logic              hs,
  input  logic              vs,
  input  logic [DW-1:0]     red,
  input  logic [DW-1:0]     green,
  input  logic [DW-1:0]     blue,
  output logic              hblank_out,
  output logic              vblank_out,
  output logic              hs_out,
  output logic              vs_out,
  output logic [DW-1:0]     red_out,
  output logic [DW-1:0]     green_out,
  output logic [DW-1:0]     blue_out,
  output logic [MODE_W-1:0] mode_active
);

  localparam logic [DW+1:0]     RND1    = (DW+2)'(1);
  localparam logic [DW+1:0]     RND2    = (DW+2)'(2);
  localparam logic [MODE_W-1:0] M_AVG   = MODE_W'(1);
  localparam logic [MODE_W-1:0] M_SMEAR = MODE_W'(2);
  localparam logic [MODE_W-1:0] M_TRAIL = MODE_W'(3);

  logic [DW-1:0] c_r, c_g, c_b;
  logic [DW-1:0] p_r, p_g, p_b;
  logic          c_hs, c_vs, c_hb, c_vb;
  logic          p_blank;
  logic          c_blank, n_blank;
  logic [DW-1:0] f_r, f_g, f_b;

  assign c_blank = c_hb | c_vb;
  assign n_blank = hblank | vblank;

  // Sums are held in DW+2 bits; the worst case 4*(2^DW-1)+2 fits, and the
  // rounded result of an all-max neighbourhood is exactly 2^DW-1.
  function automatic logic [DW-1:0] blend(
    input logic [DW-1:0]     p,
    input logic [DW-1:0]     c,
    input logic [DW-1:0]     n,
    input logic              p_blk,
    input logic              c_blk,
    input logic              n_blk,
    input logic [MODE_W-1:0] m
  );
    logic [DW+1:0] pe, ce, ne, sum;
    logic [DW-1:0] res;
    pe  = p_blk ? {2'b00, c} : {2'b00, p};
    ce  = {2'b00, c};
    ne  = n_blk ? {2'b00, c} : {2'b00, n};
    sum = '0;
    res = c;
    if (!c_blk) begin
      case (m)
        M_AVG: begin
          sum = pe + ce + RND1;
          res = sum[DW:1];
        end
        M_SMEAR: begin
          sum = pe + (ce << 1) + ne + RND2;
          res = sum[DW+1:2];
        end
        M_TRAIL: begin
          sum = pe + (ce << 1) + ce + RND2;
          res = sum[DW+1:2];
        end
        default: res = c;
      endcase
    end
    return res;
  endfunction

  // Blend each channel of the centre pixel with its neighbours.
  always_comb begin
    f_r = blend(p_r, c_r, red,   p_blank, c_blank, n_blank, mode_active);
    f_g = blend(p_g, c_g, green, p_blank, c_blank, n_blank, mode_active);
    f_b = blend(p_b, c_b, blue,  p_blank, c_blank, n_blank, mode_active);
  end

  // Stage 1: capture the incoming pixel and its sync/blank flags as C.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      c_r  <= '0;
      c_g  <= '0;
      c_b  <= '0;
      c_hs <= 1'b0;
      c_vs <= 1'b0;
      c_hb <= 1'b1;
      c_vb <= 1'b1;
    end else if (pix_ce) begin
      c_r  <= red;
      c_g  <= green;
      c_b  <= blue;
      c_hs <= hs;
      c_vs <= vs;
      c_hb <= hblank;
      c_vb <= vblank;
    end
  end

  // Stage 2: shift C into P; only its colour and blank state are needed.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      p_r     <= '0;
      p_g     <= '0;
      p_b     <= '0;
      p_blank <= 1'b1;
    end else if (pix_ce) begin
      p_r     <= c_r;
      p_g     <= c_g;
      p_b     <= c_b;
      p_blank <= c_blank;
    end
  end

  // Output register: filtered colour plus C's flags, keeping sync aligned.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      red_out    <= '0;
      green_out  <= '0;
      blue_out   <= '0;
      hs_out     <= 1'b0;
      vs_out     <= 1'b0;
      hblank_out <= 1'b1;
      vblank_out <= 1'b1;
    end else if (pix_ce) begin
      red_out    <= f_r;
      green_out  <= f_g;
      blue_out   <= f_b;
      hs_out     <= c_hs;
      vs_out     <= c_vs;
      hblank_out <= c_hb;
      vblank_out <= c_vb;
    end
  end

  // Accept a new mode only at the start of vertical blank.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      mode_active <= '0;
    end else if (pix_ce && vblank && !c_vb) begin
      mode_active <= mode;
    end
  end

endmodule

// File: tb/tb_cofi_multi.sv
// Self-checking bench for cofi_multi: directed scenarios with hand-derived
// values plus a randomized run against a pixel-history reference model.
module tb_cofi_multi;
  localparam int DW = 8;
  localparam int MW = 2;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          pix_ce = 1'b0;
  logic [MW-1:0] mode = '0;
  logic          hblank = 1'b1, vblank = 1'b1, hs = 1'b0, vs = 1'b0;
  logic [DW-1:0] red = '0, green = '0, blue = '0;
  logic          hblank_out, vblank_out, hs_out, vs_out;
  logic [DW-1:0] red_out, green_out, blue_out;
  logic [MW-1:0] mode_active;

  int checks = 0;
  int failures = 0;

  cofi_multi #(.DW(DW), .MODE_W(MW)) dut (
    .clk(clk), .reset_n(reset_n), .pix_ce(pix_ce), .mode(mode),
    .hblank(hblank), .vblank(vblank), .hs(hs), .vs(vs),
    .red(red), .green(green), .blue(blue),
    .hblank_out(hblank_out), .vblank_out(vblank_out),
    .hs_out(hs_out), .vs_out(vs_out),
    .red_out(red_out), .green_out(green_out), .blue_out(blue_out),
    .mode_active(mode_active)
  );

  always #5 clk = ~clk;

  // Reference model: the last two accepted pixels plus the mode in force.
  typedef struct { int r; int g; int b; bit hs; bit vs; bit hb; bit vb; } pix_t;
  pix_t hist[$];
  pix_t exp_p;
  int   exp_mode = 0;

  function automatic pix_t blank_pix();
    pix_t t;
    t.r = 0; t.g = 0; t.b = 0;
    t.hs = 1'b0; t.vs = 1'b0; t.hb = 1'b1; t.vb = 1'b1;
    return t;
  endfunction

  function automatic int mix(int p, int c, int n, bit pb, bit cb, bit nb, int m);
    int pp, nn;
    if (cb) return c;
    pp = pb ? c : p;
    nn = nb ? c : n;
    case (m)
      1: return (pp + c + 1) / 2;
      2: return (pp + 2 * c + nn + 2) / 4;
      3: return (pp + 3 * c + 2) / 4;
      default: return c;
    endcase
  endfunction

  task automatic model_edge();
    pix_t n, c, p;
    if (!reset_n) begin
      hist.delete();
      hist.push_back(blank_pix());
      hist.push_back(blank_pix());
      exp_p = blank_pix();
      exp_mode = 0;
    end else if (pix_ce) begin
      n.r = int'(red); n.g = int'(green); n.b = int'(blue);
      n.hs = hs; n.vs = vs; n.hb = hblank; n.vb = vblank;
      p = hist[0];
      c = hist[1];
      exp_p = c;
      exp_p.r = mix(p.r, c.r, n.r, p.hb | p.vb, c.hb | c.vb, n.hb | n.vb, exp_mode);
      exp_p.g = mix(p.g, c.g, n.g, p.hb | p.vb, c.hb | c.vb, n.hb | n.vb, exp_mode);
      exp_p.b = mix(p.b, c.b, n.b, p.hb | p.vb, c.hb | c.vb, n.hb | n.vb, exp_mode);
      if (n.vb && !c.vb) exp_mode = int'(mode);
      void'(hist.pop_front());
      hist.push_back(n);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic px(input int r, input int g, input int b, input bit hb, input bit vb,
                    input bit h = 1'b0, input bit v = 1'b0);
    red = DW'(r); green = DW'(g); blue = DW'(b);
    hblank = hb; vblank = vb; hs = h; vs = v;
    pix_ce = 1'b1;
    tick();
  endtask

  task automatic latch_mode(input int m);
    mode = MW'(m);
    px(0, 0, 0, 1'b1, 1'b0);
    px(0, 0, 0, 1'b1, 1'b1);
    px(0, 0, 0, 1'b1, 1'b0);
  endtask

  task automatic test_reset();
    reset_n = 1'b0; pix_ce = 1'b0;
    red = 8'hAA; green = 8'h55; blue = 8'h0F; hs = 1'b1; vs = 1'b1;
    hblank = 1'b0; vblank = 1'b0;
    tick();
    checks++;
    if ({red_out, green_out, blue_out} !== 24'h0) begin
      failures++;
      $display("FAIL reset_colour got=%h want=000000", {red_out, green_out, blue_out});
    end
    checks++;
    if ({hs_out, vs_out, hblank_out, vblank_out} !== 4'b0011) begin
      failures++;
      $display("FAIL reset_sync got=%b want=0011", {hs_out, vs_out, hblank_out, vblank_out});
    end
    checks++;
    if (mode_active !== 2'd0) begin
      failures++;
      $display("FAIL reset_mode got=%0d want=0", mode_active);
    end
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_avg();
    int vals[4] = '{0, 100, 200, 255};
    int want[4] = '{0, 50, 150, 228};
    latch_mode(1);
    mode = 2'd3;
    checks++;
    if (mode_active !== 2'd1) begin
      failures++;
      $display("FAIL avg_mode got=%0d want=1", mode_active);
    end
    for (int i = 0; i < 5; i++) begin
      if (i < 4) px(vals[i], 0, 0, 1'b0, 1'b0);
      else px(0, 0, 0, 1'b1, 1'b0);
      if (i >= 1) begin
        checks++;
        if (red_out !== DW'(want[i-1])) begin
          failures++;
          $display("FAIL avg_red[%0d] got=%0d want=%0d", i - 1, red_out, want[i-1]);
        end
      end
    end
  endtask

  task automatic test_smear();
    int vals[5] = '{0, 0, 255, 0, 0};
    int want[5] = '{0, 64, 128, 64, 0};
    latch_mode(2);
    checks++;
    if (mode_active !== 2'd2) begin
      failures++;
      $display("FAIL smear_mode got=%0d want=2", mode_active);
    end
    for (int i = 0; i < 6; i++) begin
      if (i < 5) px(0, vals[i], 0, 1'b0, 1'b0);
      else px(0, 0, 0, 1'b1, 1'b0);
      if (i >= 1) begin
        checks++;
        if (green_out !== DW'(want[i-1])) begin
          failures++;
          $display("FAIL smear_green[%0d] got=%0d want=%0d", i - 1, green_out, want[i-1]);
        end
      end
    end
  endtask

  task automatic test_weighted();
    int vals[2] = '{255, 0};
    int want[2] = '{255, 64};
    latch_mode(3);
    for (int i = 0; i < 3; i++) begin
      if (i < 2) px(vals[i], vals[i], vals[i], 1'b0, 1'b0);
      else px(0, 0, 0, 1'b1, 1'b0);
      if (i >= 1) begin
        checks++;
        if ({red_out, green_out, blue_out} !== {3{DW'(want[i-1])}}) begin
          failures++;
          $display("FAIL trail_edge[%0d] got=%h want=%0d each", i - 1,
                   {red_out, green_out, blue_out}, want[i-1]);
        end
      end
    end
    for (int i = 0; i < 7; i++) begin
      if (i < 6) px(255, 255, 255, 1'b0, 1'b0);
      else px(0, 0, 0, 1'b1, 1'b0);
      if (i >= 1) begin
        checks++;
        if ({red_out, green_out, blue_out} !== 24'hFFFFFF) begin
          failures++;
          $display("FAIL trail_max[%0d] got=%h want=ffffff", i - 1,
                   {red_out, green_out, blue_out});
        end
      end
    end
  endtask

  task automatic test_hblank_sync();
    int cols[6]     = '{77, 10, 20, 30, 99, 0};
    bit hbs[6]      = '{1, 0, 0, 0, 1, 1};
    bit hss[6]      = '{1, 0, 0, 0, 1, 0};
    bit vss[6]      = '{0, 0, 1, 0, 0, 0};
    int want_col[5] = '{77, 13, 20, 28, 99};
    latch_mode(2);
    for (int i = 0; i < 6; i++) begin
      px(cols[i], cols[i], cols[i], hbs[i], 1'b0, hss[i], vss[i]);
      pix_ce = 1'b0;
      red = DW'($urandom); hblank = ~hblank; hs = ~hs; vs = ~vs;
      vblank = 1'b1; mode = 2'd0;
      tick();
      if (i >= 1) begin
        checks++;
        if (red_out !== DW'(want_col[i-1])) begin
          failures++;
          $display("FAIL hb_colour[%0d] got=%0d want=%0d", i - 1, red_out, want_col[i-1]);
        end
        checks++;
        if ({hs_out, vs_out, hblank_out, vblank_out} !== {hss[i-1], vss[i-1], hbs[i-1], 1'b0}) begin
          failures++;
          $display("FAIL hb_sync[%0d] got=%b want=%b", i - 1,
                   {hs_out, vs_out, hblank_out, vblank_out}, {hss[i-1], vss[i-1], hbs[i-1], 1'b0});
        end
      end
    end
    checks++;
    if (mode_active !== 2'd2) begin
      failures++;
      $display("FAIL hb_mode_gated got=%0d want=2", mode_active);
    end
  endtask

  task automatic test_mode_change();
    latch_mode(1);
    mode = 2'd2;
    for (int i = 0; i < 8; i++) begin
      px($urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 255), 1'b0, 1'b0);
      checks++;
      if (mode_active !== 2'd1 || red_out !== DW'(exp_p.r)) begin
        failures++;
        $display("FAIL midframe[%0d] got mode=%0d red=%0d want mode=1 red=%0d",
                 i, mode_active, red_out, exp_p.r);
      end
    end
    for (int i = 0; i < 5; i++) begin
      pix_ce = 1'b0;
      red = DW'($urandom); green = DW'($urandom); blue = DW'($urandom);
      hblank = 1'($urandom); vblank = 1'($urandom); hs = 1'($urandom); vs = 1'($urandom);
      tick();
      checks++;
      if ({red_out, green_out, blue_out, hs_out, vs_out, hblank_out, vblank_out, mode_active} !==
          {DW'(exp_p.r), DW'(exp_p.g), DW'(exp_p.b), exp_p.hs, exp_p.vs, exp_p.hb, exp_p.vb, 2'd1}) begin
        failures++;
        $display("FAIL hold[%0d] got red=%0d mode=%0d want red=%0d mode=1",
                 i, red_out, mode_active, exp_p.r);
      end
    end
    px(0, 0, 0, 1'b1, 1'b0);
    px(0, 0, 0, 1'b1, 1'b1);
    checks++;
    if (mode_active !== 2'd2) begin
      failures++;
      $display("FAIL vblank_latch got=%0d want=2", mode_active);
    end
  endtask

  task automatic test_reset_mid();
    int vals[4] = '{40, 80, 120, 160};
    latch_mode(2);
    px(200, 200, 200, 1'b0, 1'b0);
    px(10, 10, 10, 1'b0, 1'b0);
    reset_n = 1'b0;
    px(123, 45, 67, 1'b0, 1'b0, 1'b1, 1'b1);
    checks++;
    if ({red_out, green_out, blue_out, hs_out, vs_out, hblank_out, vblank_out, mode_active} !==
        {24'h0, 4'b0011, 2'd0}) begin
      failures++;
      $display("FAIL midreset got=%h want=%h",
               {red_out, green_out, blue_out, hs_out, vs_out, hblank_out, vblank_out, mode_active},
               {24'h0, 4'b0011, 2'd0});
    end
    reset_n = 1'b1;
    mode = 2'd3;
    for (int i = 0; i < 5; i++) begin
      if (i < 4) px(vals[i], vals[i], vals[i], 1'b0, 1'b0);
      else px(0, 0, 0, 1'b1, 1'b0);
      checks++;
      if (i == 0) begin
        if (red_out !== 8'd0 || hblank_out !== 1'b1) begin
          failures++;
          $display("FAIL post_reset[0] got red=%0d hb=%b want red=0 hb=1", red_out, hblank_out);
        end
      end else if (red_out !== DW'(vals[i-1]) || hblank_out !== 1'b0 || mode_active !== 2'd0) begin
        failures++;
        $display("FAIL post_reset[%0d] got red=%0d hb=%b mode=%0d want red=%0d hb=0 mode=0",
                 i, red_out, hblank_out, mode_active, vals[i-1]);
      end
    end
  endtask

  task automatic test_random();
    int col = 0;
    int line = 0;
    logic [3*DW+4+MW-1:0] got, want;
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      pix_ce  = ($urandom_range(0, 3) != 0);
      reset_n = ($urandom_range(0, 999) != 0);
      if (cyc % 150 == 0) mode = MW'($urandom_range(0, 3));
      hblank = (col >= 16);
      vblank = (line >= 5);
      hs     = (col >= 18 && col < 21);
      vs     = (line == 5);
      if ($urandom_range(0, 3) == 0) begin
        red   = $urandom_range(0, 1) ? 8'hFF : 8'h00;
        green = $urandom_range(0, 1) ? 8'hFF : 8'h00;
        blue  = $urandom_range(0, 1) ? 8'hFF : 8'h00;
      end else begin
        red = DW'($urandom); green = DW'($urandom); blue = DW'($urandom);
      end
      tick();
      if (pix_ce) begin
        col = (col + 1) % 24;
        if (col == 0) line = (line + 1) % 7;
      end
      got  = {red_out, green_out, blue_out, hs_out, vs_out, hblank_out, vblank_out, mode_active};
      want = {DW'(exp_p.r), DW'(exp_p.g), DW'(exp_p.b), exp_p.hs, exp_p.vs, exp_p.hb, exp_p.vb,
              MW'(exp_mode)};
      checks++;
      if (got !== want) begin
        failures++;
        $display("FAIL random[%0d] got=%h want=%h", cyc, got, want);
      end
    end
    reset_n = 1'b1;
  endtask

  initial begin
    hist.push_back(blank_pix());
    hist.push_back(blank_pix());
    exp_p = blank_pix();
    test_reset();
    test_avg();
    test_smear();
    test_weighted();
    test_hblank_sync();
    test_mode_change();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
